// File: rtl/sb_pkg.sv
// Shared types and constants for the store buffer and its entry FIFO.
package sb_pkg;

    // Default memory word-address width (128-word data memory).
    localparam int SB_AW = 7;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // One posted store: word address, byte offset, size code and raw data.
    typedef struct packed {
        logic [SB_AW-1:0] waddr;
        logic [1:0]       offset;
        logic [1:0]       size;
        logic [31:0]      data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular FIFO of pending stores. It exposes a per-slot valid flag and word
// address so the parent can compare every pending entry against a load.
module store_buffer_fifo
    import sb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  sb_entry_t        push_entry,
    input  logic             pop,
    output sb_entry_t        head_entry,
    output logic [CW-1:0]    count,
    output logic [DEPTH-1:0] entry_valid,
    output logic [SB_AW-1:0] entry_waddr [DEPTH]
);

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    sb_entry_t     mem [DEPTH];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry payload storage; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= push_entry;
    end

    assign head_entry = mem[head];

    // A slot is live when its distance from head is below the occupancy.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid[i] = {1'b0, PW'(PW'(i) - head)} < count;
            entry_waddr[i] = mem[i].waddr;
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer in front of the data memory write port. Owns the memory
// address mux: stores drain when the port is free or a load must wait on them.
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = SB_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [31:0]   st_addr,
    input  logic [31:0]   st_data,
    input  logic [1:0]    st_size,
    input  logic          ld_valid,
    input  logic [31:0]   ld_addr,
    output logic          ld_hazard,
    output logic          sb_empty,
    output logic [AW-1:0] DMAdd,
    output logic          DMW,
    output logic          SpecialIn,
    output logic          BorH,
    output logic [1:0]    LastTwo,
    output logic [31:0]   DataIn
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]    count;
    logic [DEPTH-1:0] entry_valid;
    logic [AW-1:0]    entry_waddr [DEPTH];
    sb_entry_t        head_entry;
    sb_entry_t        push_entry;
    logic             push;
    logic             drain_en;
    logic             hit;
    logic [AW-1:0]    ld_word;
    logic             unused_addr_bits;

    // Full check uses registered occupancy only, so a same-cycle pop never frees a slot early.
    assign st_ready = count < CW'(DEPTH);
    assign sb_empty = (count == '0);
    assign push     = st_valid && st_ready;
    assign ld_word  = ld_addr[AW+1:2];

    assign push_entry.waddr  = st_addr[AW+1:2];
    assign push_entry.offset = st_addr[1:0];
    assign push_entry.size   = st_size;
    assign push_entry.data   = st_data;

    assign unused_addr_bits = ^{st_addr[31:AW+2], ld_addr[31:AW+2], ld_addr[1:0]};

    store_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (drain_en),
        .head_entry  (head_entry),
        .count       (count),
        .entry_valid (entry_valid),
        .entry_waddr (entry_waddr)
    );

    // Word-granular match of the load against every pending store.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entry_waddr[i] == ld_word)) hit = 1'b1;
        end
    end

    assign ld_hazard = ld_valid && hit;
    assign drain_en  = (count != '0) && (!ld_valid || ld_hazard);

    // Memory-side mux: the head entry owns the port while draining, otherwise the load does.
    always_comb begin
        DMW       = 1'b0;
        DMAdd     = ld_word;
        SpecialIn = 1'b0;
        BorH      = 1'b0;
        LastTwo   = 2'b00;
        DataIn    = 32'h0;
        if (drain_en) begin
            DMW       = 1'b1;
            DMAdd     = head_entry.waddr;
            SpecialIn = (head_entry.size == SZ_BYTE) || (head_entry.size == SZ_HALF);
            BorH      = (head_entry.size == SZ_HALF);
            LastTwo   = head_entry.offset;
            DataIn    = head_entry.data;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: reset, sub-word drain, fill/backpressure,
// load hazard stall, concurrent push/pop with wrap, and size 11 handling.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_size;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic        sb_empty;
    logic [6:0]  DMAdd;
    logic        DMW;
    logic        SpecialIn;
    logic        BorH;
    logic [1:0]  LastTwo;
    logic [31:0] DataIn;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } st_t;

    st_t exp_q[$];

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4), .AW(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_size   (st_size),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_hazard (ld_hazard),
        .sb_empty  (sb_empty),
        .DMAdd     (DMAdd),
        .DMW       (DMW),
        .SpecialIn (SpecialIn),
        .BorH      (BorH),
        .LastTwo   (LastTwo),
        .DataIn    (DataIn)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("miscompare at %s", tag);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_st(input st_t s);
        st_valid = 1'b1;
        st_addr  = s.addr;
        st_data  = s.data;
        st_size  = s.size;
    endtask

    // Check the drain of the oldest expected store.
    task automatic chk_drain(input string tag);
        st_t e;
        e = exp_q.pop_front();
        chk({tag, " DMW"},       {31'b0, DMW},       32'd1);
        chk({tag, " DMAdd"},     {25'b0, DMAdd},     {25'b0, e.addr[8:2]});
        chk({tag, " DataIn"},    DataIn,             e.data);
        chk({tag, " LastTwo"},   {30'b0, LastTwo},   {30'b0, e.addr[1:0]});
        chk({tag, " SpecialIn"}, {31'b0, SpecialIn}, {31'b0, (e.size == 2'b00) || (e.size == 2'b01)});
        chk({tag, " BorH"},      {31'b0, BorH},      {31'b0, e.size == 2'b01});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        st_t s;
        rst_n    = 1'b0;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        st_size  = '0;
        ld_valid = 1'b0;
        ld_addr  = 32'h44;
        repeat (2) cyc();

        // Reset values
        chk("rst st_ready",  {31'b0, st_ready},  32'd1);
        chk("rst sb_empty",  {31'b0, sb_empty},  32'd1);
        chk("rst ld_hazard", {31'b0, ld_hazard}, 32'd0);
        chk("rst DMW",       {31'b0, DMW},       32'd0);
        chk("rst DMAdd",     {25'b0, DMAdd},     32'd17);
        chk("rst SpecialIn", {31'b0, SpecialIn}, 32'd0);
        chk("rst BorH",      {31'b0, BorH},      32'd0);
        chk("rst LastTwo",   {30'b0, LastTwo},   32'd0);
        chk("rst DataIn",    DataIn,             32'd0);
        rst_n = 1'b1;

        // Reset with stores pending
        ld_valid = 1'b1;
        ld_addr  = 32'h100;
        drive_st('{32'h10, 32'h1, 2'b10});
        cyc();
        drive_st('{32'h14, 32'h2, 2'b10});
        cyc();
        st_valid = 1'b0;
        #1;
        chk("pend sb_empty", {31'b0, sb_empty}, 32'd0);
        chk("pend DMW blocked", {31'b0, DMW}, 32'd0);
        ld_valid = 1'b0;
        #1;
        chk("pend DMW", {31'b0, DMW}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst sb_empty", {31'b0, sb_empty}, 32'd1);
        chk("midrst st_ready", {31'b0, st_ready}, 32'd1);
        chk("midrst DMW",      {31'b0, DMW},      32'd0);
        cyc();
        rst_n = 1'b1;
        #1;
        chk("postrst DMW", {31'b0, DMW}, 32'd0);
        cyc();
        chk("postrst DMW2",     {31'b0, DMW},      32'd0);
        chk("postrst sb_empty", {31'b0, sb_empty}, 32'd1);

        // Byte store, no bypass in acceptance cycle
        s = '{32'h13, 32'hAB, 2'b00};
        drive_st(s);
        #1;
        chk("byte no bypass", {31'b0, DMW}, 32'd0);
        cyc();
        st_valid = 1'b0;
        exp_q.push_back(s);
        #1;
        chk_drain("byte");
        chk("byte DMAdd4", {25'b0, DMAdd}, 32'd4);
        cyc();
        chk("byte empty", {31'b0, sb_empty}, 32'd1);
        chk("byte DMW off", {31'b0, DMW}, 32'd0);

        // Fill under a non-matching load, then drain in order
        ld_valid = 1'b1;
        ld_addr  = 32'h200;
        for (int i = 0; i < 4; i++) begin
            s = '{32'h40 + 32'(4 * i), 32'h11 * 32'(i + 1), 2'b10};
            drive_st(s);
            exp_q.push_back(s);
            #1;
            chk("fill DMW", {31'b0, DMW}, 32'd0);
            cyc();
        end
        drive_st('{32'h50, 32'h55, 2'b10});
        #1;
        chk("full st_ready", {31'b0, st_ready}, 32'd0);
        chk("full hazard",   {31'b0, ld_hazard}, 32'd0);
        cyc();
        st_valid = 1'b0;
        ld_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain st_ready", {31'b0, st_ready}, (i == 0) ? 32'd0 : 32'd1);
            chk_drain("fill drain");
            cyc();
        end
        chk("fill fifth dropped", {31'b0, DMW}, 32'd0);
        chk("fill empty", {31'b0, sb_empty}, 32'd1);

        // Halfword store then hazarding load
        s = '{32'h20, 32'h1234, 2'b01};
        drive_st(s);
        cyc();
        st_valid = 1'b0;
        exp_q.push_back(s);
        ld_valid = 1'b1;
        ld_addr  = 32'h22;
        #1;
        chk("haz ld_hazard", {31'b0, ld_hazard}, 32'd1);
        chk_drain("haz");
        chk("haz DMAdd8", {25'b0, DMAdd}, 32'd8);
        cyc();
        chk("haz clear",     {31'b0, ld_hazard}, 32'd0);
        chk("haz ld DMAdd",  {25'b0, DMAdd},     32'd8);
        chk("haz ld DMW",    {31'b0, DMW},       32'd0);
        chk("haz ld BorH",   {31'b0, BorH},      32'd0);
        ld_valid = 1'b0;

        // Concurrent push/pop at count=2 with pointer wrap over 12 stores
        ld_valid = 1'b1;
        ld_addr  = 32'h200;
        for (int i = 0; i < 12; i++) begin
            logic [1:0] sz;
            logic [1:0] off;
            sz  = 2'(i % 3);
            off = (sz == 2'b00) ? 2'(i % 4) : (sz == 2'b01) ? 2'(2 * (i % 2)) : 2'b00;
            s = '{32'h180 + 32'(4 * i) + {30'b0, off}, 32'hA000_0000 + 32'(i), sz};
            drive_st(s);
            if (i >= 2) begin
                ld_valid = 1'b0;
                #1;
                chk("wrap st_ready", {31'b0, st_ready}, 32'd1);
                chk("wrap sb_empty", {31'b0, sb_empty}, 32'd0);
                chk_drain("wrap");
            end
            exp_q.push_back(s);
            cyc();
        end
        st_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk_drain("wrap tail");
            cyc();
        end
        chk("wrap empty", {31'b0, sb_empty}, 32'd1);
        chk("wrap queue", 32'(exp_q.size()), 32'd0);

        // Size 11 behaves as a word store
        s = '{32'h7C, 32'hDEADBEEF, 2'b11};
        drive_st(s);
        cyc();
        st_valid = 1'b0;
        #1;
        chk("sz11 DMW",       {31'b0, DMW},       32'd1);
        chk("sz11 SpecialIn", {31'b0, SpecialIn}, 32'd0);
        chk("sz11 BorH",      {31'b0, BorH},      32'd0);
        chk("sz11 DMAdd",     {25'b0, DMAdd},     32'd31);
        chk("sz11 DataIn",    DataIn,             32'hDEADBEEF);
        cyc();
        chk("sz11 empty", {31'b0, sb_empty}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
